// File: rtl/field_queue.sv
// Ready/valid FIFO for one WIDTH-bit sideband field between interconnect stages.
// Optional FLOW (empty bypass) and PIPE (enq while full if deq fires) modes.
module field_queue #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 2,
  parameter bit          FLOW  = 1'b0,
  parameter bit          PIPE  = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [WIDTH-1:0]           enq_bits,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [WIDTH-1:0]           deq_bits,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CWW = CW + 1;

  // Handshake: a word transfers on a side exactly in a cycle where its valid
  // and ready are both high at the rising edge; valid must not wait on ready.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    enq_ptr, deq_ptr;
  logic             maybe_full;
  logic             ptr_match, empty, full, bypass;
  logic             do_enq, do_deq, wr_en, rd_en;
  logic [CW:0]      cnt_wide;

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match && !maybe_full;
  assign full      = ptr_match && maybe_full;

  always_comb begin
    enq_ready = !full;
    deq_valid = !empty;
    deq_bits  = mem[deq_ptr];
    bypass    = 1'b0;
    if (FLOW && empty) begin
      deq_valid = enq_valid;
      deq_bits  = enq_bits;
      bypass    = deq_ready;
    end
    if (PIPE && full) begin
      enq_ready = deq_ready;
    end
  end

  assign do_enq = enq_valid && enq_ready;
  assign do_deq = deq_valid && deq_ready;
  // A bypassed word never touches storage, pointers or the full flag.
  assign wr_en  = do_enq && !bypass;
  assign rd_en  = do_deq && !bypass;

  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
    end else begin
      if (wr_en) begin
        enq_ptr <= (enq_ptr == PW'(DEPTH - 1)) ? '0 : enq_ptr + PW'(1);
      end
      if (rd_en) begin
        deq_ptr <= (deq_ptr == PW'(DEPTH - 1)) ? '0 : deq_ptr + PW'(1);
      end
      if (wr_en != rd_en) begin
        maybe_full <= wr_en;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      mem[enq_ptr] <= enq_bits;
    end
  end

  always_comb begin
    if (ptr_match) begin
      cnt_wide = maybe_full ? CWW'(DEPTH) : '0;
    end else if (enq_ptr > deq_ptr) begin
      cnt_wide = CWW'(enq_ptr) - CWW'(deq_ptr);
    end else begin
      cnt_wide = CWW'(DEPTH) + CWW'(enq_ptr) - CWW'(deq_ptr);
    end
  end

  assign count = cnt_wide[CW-1:0];

endmodule

// File: tb/tb_field_queue.sv
// Directed bench for field_queue: base, wrap, FLOW, PIPE and mid-operation reset
// configurations, each on its own instance sharing one clock.
module tb_field_queue;

  logic clock;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // base: WIDTH=3 DEPTH=2
  logic       b_reset, b_enq_valid, b_enq_ready, b_deq_valid, b_deq_ready;
  logic [2:0] b_enq_bits, b_deq_bits;
  logic [1:0] b_count;
  // wrap: WIDTH=8 DEPTH=3
  logic       w_reset, w_enq_valid, w_enq_ready, w_deq_valid, w_deq_ready;
  logic [7:0] w_enq_bits, w_deq_bits;
  logic [1:0] w_count;
  // flow: FLOW=1 DEPTH=2
  logic       f_reset, f_enq_valid, f_enq_ready, f_deq_valid, f_deq_ready;
  logic [2:0] f_enq_bits, f_deq_bits;
  logic [1:0] f_count;
  // pipe: PIPE=1 DEPTH=1
  logic       p_reset, p_enq_valid, p_enq_ready, p_deq_valid, p_deq_ready;
  logic [2:0] p_enq_bits, p_deq_bits;
  logic [0:0] p_count;
  // reset: DEPTH=4
  logic       r_reset, r_enq_valid, r_enq_ready, r_deq_valid, r_deq_ready;
  logic [2:0] r_enq_bits, r_deq_bits;
  logic [2:0] r_count;

  logic [7:0] exp_q[$];

  field_queue #(.WIDTH(3), .DEPTH(2)) u_base (
    .clock(clock), .reset(b_reset), .enq_valid(b_enq_valid), .enq_ready(b_enq_ready),
    .enq_bits(b_enq_bits), .deq_valid(b_deq_valid), .deq_ready(b_deq_ready),
    .deq_bits(b_deq_bits), .count(b_count));

  field_queue #(.WIDTH(8), .DEPTH(3)) u_wrap (
    .clock(clock), .reset(w_reset), .enq_valid(w_enq_valid), .enq_ready(w_enq_ready),
    .enq_bits(w_enq_bits), .deq_valid(w_deq_valid), .deq_ready(w_deq_ready),
    .deq_bits(w_deq_bits), .count(w_count));

  field_queue #(.WIDTH(3), .DEPTH(2), .FLOW(1'b1)) u_flow (
    .clock(clock), .reset(f_reset), .enq_valid(f_enq_valid), .enq_ready(f_enq_ready),
    .enq_bits(f_enq_bits), .deq_valid(f_deq_valid), .deq_ready(f_deq_ready),
    .deq_bits(f_deq_bits), .count(f_count));

  field_queue #(.WIDTH(3), .DEPTH(1), .PIPE(1'b1)) u_pipe (
    .clock(clock), .reset(p_reset), .enq_valid(p_enq_valid), .enq_ready(p_enq_ready),
    .enq_bits(p_enq_bits), .deq_valid(p_deq_valid), .deq_ready(p_deq_ready),
    .deq_bits(p_deq_bits), .count(p_count));

  field_queue #(.WIDTH(3), .DEPTH(4)) u_rst (
    .clock(clock), .reset(r_reset), .enq_valid(r_enq_valid), .enq_ready(r_enq_ready),
    .enq_bits(r_enq_bits), .deq_valid(r_deq_valid), .deq_ready(r_deq_ready),
    .deq_bits(r_deq_bits), .count(r_count));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int next_in;
    int received;
    int cyc;

    b_reset = 1; w_reset = 1; f_reset = 1; p_reset = 1; r_reset = 1;
    b_enq_valid = 0; b_enq_bits = '0; b_deq_ready = 0;
    w_enq_valid = 0; w_enq_bits = '0; w_deq_ready = 0;
    f_enq_valid = 0; f_enq_bits = '0; f_deq_ready = 0;
    p_enq_valid = 0; p_enq_bits = '0; p_deq_ready = 0;
    r_enq_valid = 0; r_enq_bits = '0; r_deq_ready = 0;
    tick();
    tick();

    // Outputs while in reset
    check("rst_b_enq_ready", 32'(b_enq_ready), 32'd1);
    check("rst_b_count",     32'(b_count),     32'd0);
    check("rst_b_deq_valid", 32'(b_deq_valid), 32'd0);
    f_enq_valid = 1; f_enq_bits = 3'h3;
    #1;
    check("rst_f_deq_valid_follows", 32'(f_deq_valid), 32'd1);
    f_enq_valid = 0;
    #1;
    check("rst_f_deq_valid_low", 32'(f_deq_valid), 32'd0);

    b_reset = 0; w_reset = 0; f_reset = 0; p_reset = 0; r_reset = 0;
    tick();
    check("post_rst_b_enq_ready", 32'(b_enq_ready), 32'd1);
    check("post_rst_b_count",     32'(b_count),     32'd0);
    check("post_rst_r_count",     32'(r_count),     32'd0);

    // Fill base queue
    b_enq_valid = 1; b_enq_bits = 3'h5;
    #1;
    check("fill_ready0", 32'(b_enq_ready), 32'd1);
    tick();
    check("fill_count1", 32'(b_count),     32'd1);
    check("fill_valid1", 32'(b_deq_valid), 32'd1);
    check("fill_bits1",  32'(b_deq_bits),  32'h5);
    b_enq_bits = 3'h2;
    #1;
    check("fill_ready1", 32'(b_enq_ready), 32'd1);
    tick();
    b_enq_valid = 0;
    #1;
    check("fill_count2", 32'(b_count),     32'd2);
    check("fill_full",   32'(b_enq_ready), 32'd0);
    check("fill_bits2",  32'(b_deq_bits),  32'h5);

    // Drain in order
    b_deq_ready = 1;
    #1;
    check("drain_bits0",  32'(b_deq_bits), 32'h5);
    tick();
    check("drain_bits1",  32'(b_deq_bits), 32'h2);
    check("drain_count1", 32'(b_count),    32'd1);
    tick();
    check("drain_count0", 32'(b_count),     32'd0);
    check("drain_empty",  32'(b_deq_valid), 32'd0);
    b_deq_ready = 0;

    // Wrap-around on DEPTH=3 with toggling consumer
    next_in = 0;
    received = 0;
    cyc = 0;
    while ((received < 10) && (cyc < 200)) begin
      w_enq_valid = (next_in < 10);
      w_enq_bits  = 8'(next_in);
      w_deq_ready = cyc[0];
      #1;
      check("wrap_count", 32'(w_count), 32'(exp_q.size()));
      if (w_deq_valid && w_deq_ready) begin
        if (exp_q.size() == 0) begin
          check("wrap_unexpected_out", 32'(w_deq_bits), 32'hFFFF_FFFF);
        end else begin
          check("wrap_order", 32'(w_deq_bits), 32'(exp_q.pop_front()));
        end
        received++;
      end
      if (w_enq_valid && w_enq_ready) begin
        exp_q.push_back(8'(next_in));
        next_in++;
      end
      tick();
      cyc++;
    end
    w_enq_valid = 0; w_deq_ready = 0;
    check("wrap_received", 32'(received), 32'd10);

    // FLOW bypass
    f_enq_valid = 1; f_enq_bits = 3'h7; f_deq_ready = 1;
    #1;
    check("flow_valid",   32'(f_deq_valid), 32'd1);
    check("flow_bits",    32'(f_deq_bits),  32'h7);
    check("flow_count",   32'(f_count),     32'd0);
    tick();
    f_enq_valid = 0;
    #1;
    check("flow_after_count", 32'(f_count),     32'd0);
    check("flow_after_valid", 32'(f_deq_valid), 32'd0);
    f_enq_valid = 1; f_deq_ready = 0;
    #1;
    check("flow_nobyp_valid", 32'(f_deq_valid), 32'd1);
    tick();
    f_enq_valid = 0;
    #1;
    check("flow_nobyp_count", 32'(f_count),    32'd1);
    check("flow_nobyp_bits",  32'(f_deq_bits), 32'h7);
    f_deq_ready = 1;
    tick();
    f_deq_ready = 0;
    check("flow_drained", 32'(f_count), 32'd0);

    // PIPE full pass-through on DEPTH=1
    p_enq_valid = 1; p_enq_bits = 3'h1;
    tick();
    p_enq_valid = 0;
    #1;
    check("pipe_full_count", 32'(p_count),     32'd1);
    check("pipe_full_ready", 32'(p_enq_ready), 32'd0);
    p_enq_valid = 1; p_enq_bits = 3'h4; p_deq_ready = 1;
    #1;
    check("pipe_ready",     32'(p_enq_ready), 32'd1);
    check("pipe_old_bits",  32'(p_deq_bits),  32'h1);
    tick();
    p_enq_valid = 0; p_deq_ready = 0;
    #1;
    check("pipe_new_bits",  32'(p_deq_bits), 32'h4);
    check("pipe_count",     32'(p_count),    32'd1);

    // Mid-operation reset on DEPTH=4
    r_enq_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      r_enq_bits = 3'(i);
      tick();
    end
    r_enq_valid = 0;
    #1;
    check("rstmid_count3", 32'(r_count), 32'd3);
    r_enq_valid = 1; r_enq_bits = 3'h6; r_reset = 1;
    tick();
    r_reset = 0; r_enq_valid = 0;
    #1;
    check("rstmid_count",     32'(r_count),     32'd0);
    check("rstmid_deq_valid", 32'(r_deq_valid), 32'd0);
    check("rstmid_enq_ready", 32'(r_enq_ready), 32'd1);
    r_deq_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_stays_empty", 32'(r_deq_valid), 32'd0);
    end
    r_deq_ready = 0;
    r_enq_valid = 1; r_enq_bits = 3'h5;
    tick();
    r_enq_valid = 0;
    #1;
    check("rstmid_new_count", 32'(r_count),    32'd1);
    check("rstmid_new_bits",  32'(r_deq_bits), 32'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/field_queue.md
# field_queue

Parametrised ready/valid FIFO that carries one WIDTH-bit sideband field (opcode, param or size) between two pipeline stages of the core-complex interconnect. It replaces the earlier fixed 3-bit combinational field passthrough where a stage boundary needs buffering, backpressure or retiming. Behaviour matches the team's standard queue semantics, including the optional FLOW (empty bypass) and PIPE (full pass-through) modes.

## Interface
- WIDTH, 3: field width in bits, >= 1.
- DEPTH, 2: number of entries, >= 1; non-power-of-two values are legal.
- FLOW, 0: 1 = a word may pass combinationally from enq to deq when the queue is empty.
- PIPE, 0: 1 = enq_ready also asserts when full and deq fires in the same cycle.
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- enq_valid  input  1  producer offers enq_bits.
- enq_ready  output  1  queue accepts enq_bits this cycle.
- enq_bits  input  WIDTH  incoming field.
- deq_valid  output  1  deq_bits is valid.
- deq_ready  input  1  consumer takes deq_bits.
- deq_bits  output  WIDTH  outgoing field.
- count  output  clog2(DEPTH+1)  current occupancy, 0..DEPTH.

## Operation
- State: storage array mem[DEPTH] of WIDTH bits, enq_ptr and deq_ptr (0..DEPTH-1), and a maybe_full flag.
- empty = (enq_ptr == deq_ptr) && !maybe_full. full = (enq_ptr == deq_ptr) && maybe_full.
- Handshakes: do_enq = enq_valid && enq_ready. do_deq = deq_valid && deq_ready.
- Base case: enq_ready = !full. deq_valid = !empty. deq_bits = mem[deq_ptr].
- FLOW=1 and empty:
  - deq_valid = enq_valid and deq_bits = enq_bits.
  - If deq_ready is high, the word bypasses the queue: no write and no pointer or flag change.
  - If deq_ready is low, the word is written normally.
- PIPE=1 and full: enq_ready = deq_ready.
- Write side: on do_enq (not bypassed), mem[enq_ptr] <= enq_bits and enq_ptr advances.
- Read side: on do_deq (not bypassed), deq_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 wraps to 0 on advance. Power-of-two DEPTH must not be assumed.
- maybe_full update: when do_enq != do_deq (after bypass suppression), maybe_full <= do_enq. Otherwise it holds.
- count:
  - enq_ptr == deq_ptr: count = DEPTH if maybe_full, else 0.
  - enq_ptr > deq_ptr: count = enq_ptr - deq_ptr.
  - otherwise: count = DEPTH + enq_ptr - deq_ptr.
  - Computed in clog2(DEPTH+1)+1 bits, then truncated.
- Simultaneous enq and deq at partial occupancy: both pointers advance, maybe_full and count are unchanged.
- deq_bits is don't-care whenever deq_valid = 0. The bench must not check it then.
- The producer must hold enq_valid and enq_bits until acceptance. The queue makes no guarantee if the producer does not.

## Timing
- Reset (sync, active-high) clears enq_ptr = 0, deq_ptr = 0, maybe_full = 0. The storage array is not reset.
- Output values while in reset and on the first cycle after it:
  - enq_ready = 1, count = 0.
  - deq_valid = 0, or = enq_valid when FLOW=1.
- Reset asserted mid-operation discards all entries at the next edge. Any handshake in that cycle is ignored.
- Latency enq to deq: 1 cycle in the base case. 0 cycles with FLOW=1 when empty.
- Throughput: one transfer per cycle sustained at any occupancy, provided DEPTH >= 2 or PIPE = 1.
- With DEPTH=1 and PIPE=0: throughput is 1 word per 2 cycles under continuous traffic.
- Combinational paths:
  - enq_ready depends on deq_ready only when PIPE=1.
  - deq_valid and deq_bits depend on enq_valid and enq_bits only when FLOW=1.
  - count depends on registers only.

## Test plan
- Reset then fill: DEPTH=2, enq 3'h5 then 3'h2 with deq_ready=0 -> count goes 1 then 2, enq_ready=0 after the second word, deq_bits=3'h5.
- Drain and order: continue from full, deq_ready=1 for 2 cycles -> deq_bits is 3'h5 then 3'h2, count 2→1→0, deq_valid=0 afterwards.
- Wrap-around: DEPTH=3, WIDTH=8, stream 0x00..0x09 with deq_ready toggling every other cycle -> output order is exact, count never exceeds 3, pointers wrap without loss.
- FLOW bypass: FLOW=1, empty, enq 3'h7 with deq_ready=1 -> deq_valid=1 and deq_bits=3'h7 in the same cycle, count stays 0. Repeat with deq_ready=0 -> count becomes 1.
- PIPE full pass-through: PIPE=1, DEPTH=1, full with 3'h1, then enq 3'h4 with deq_ready=1 -> enq_ready=1, both fire, next cycle deq_bits=3'h4 and count=1.
- Mid-operation reset: DEPTH=4 holding 3 words, reset for 1 cycle during an enq -> next cycle count=0, deq_valid=0, enq_ready=1, and the old data never appears at deq.
